// File: rtl/tron_move_scheduler.sv
// Movement-tick controller for the two-player light-cycle game: steps both heads once per tick,
// checks walls, head-on contact and trails via the shared trail-memory port, then plots the new heads.
`timescale 1ns/1ps
module tron_move_scheduler #(
    parameter int TICK_DIV = 1666666,
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119,
    parameter int P1_X0    = 20,
    parameter int P1_Y0    = 60,
    parameter int P2_X0    = 140,
    parameter int P2_Y0    = 60
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] dir1,
    input  logic [1:0] dir2,
    output logic       rd_req,
    output logic [7:0] rd_x,
    output logic [6:0] rd_y,
    input  logic       rd_valid,
    input  logic       rd_data,
    output logic       plot,
    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    output logic [2:0] plot_colour,
    output logic [7:0] x1,
    output logic [6:0] y1,
    output logic [7:0] x2,
    output logic [6:0] y2,
    output logic [1:0] crash,
    output logic       game_over,
    output logic       busy,
    output logic [3:0] fsm_state
);
    typedef enum logic [3:0] {
        IDLE, INIT1, INIT2, WAIT_TICK, STEP, CHECK1, CHECK2, RESOLVE, PLOT1, PLOT2, OVER
    } state_t;

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic signed [8:0] X_LIM = 9'(X_MAX);
    localparam logic signed [7:0] Y_LIM = 8'(Y_MAX);

    state_t state, state_next;
    logic [TICK_W-1:0] tick_cnt;
    logic [1:0] heading1, heading2;
    logic [1:0] new_h1, new_h2;
    logic signed [8:0] cx1, cx2, cx1_q, cx2_q;
    logic signed [7:0] cy1, cy2, cy1_q, cy2_q;
    logic wall1, wall2, same;

    // A request that exactly reverses the current heading differs only in bit 1.
    function automatic logic [1:0] pick_heading(input logic [1:0] cur, input logic [1:0] req);
        return (req == (cur ^ 2'b10)) ? cur : req;
    endfunction

    function automatic logic signed [8:0] step_x(input logic [7:0] x, input logic [1:0] h);
        logic signed [8:0] v;
        v = $signed({1'b0, x});
        if (h == 2'b01)      v = v + 9'sd1;
        else if (h == 2'b11) v = v - 9'sd1;
        return v;
    endfunction

    function automatic logic signed [7:0] step_y(input logic [6:0] y, input logic [1:0] h);
        logic signed [7:0] v;
        v = $signed({1'b0, y});
        if (h == 2'b00)      v = v + 8'sd1;
        else if (h == 2'b10) v = v - 8'sd1;
        return v;
    endfunction

    always_comb begin
        new_h1 = pick_heading(heading1, dir1);
        new_h2 = pick_heading(heading2, dir2);
        cx1    = step_x(x1, new_h1);
        cy1    = step_y(y1, new_h1);
        cx2    = step_x(x2, new_h2);
        cy2    = step_y(y2, new_h2);
        wall1  = cx1[8] | (cx1 > X_LIM) | cy1[7] | (cy1 > Y_LIM);
        wall2  = cx2[8] | (cx2 > X_LIM) | cy2[7] | (cy2 > Y_LIM);
        same   = (cx1 == cx2) && (cy1 == cy2);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = INIT1;
            INIT1:     state_next = INIT2;
            INIT2:     state_next = WAIT_TICK;
            WAIT_TICK: if (tick_cnt == TICK_LAST) state_next = STEP;
            STEP:      state_next = CHECK1;
            CHECK1:    if (crash[0] || (rd_req && rd_valid)) state_next = CHECK2;
            CHECK2:    if (crash[1] || (rd_req && rd_valid)) state_next = RESOLVE;
            RESOLVE:   state_next = (crash != 2'b00) ? OVER : PLOT1;
            PLOT1:     state_next = PLOT2;
            PLOT2:     state_next = WAIT_TICK;
            OVER:      state_next = OVER;
            default:   state_next = IDLE;
        endcase
    end

    // Read handshake: rd_req rises in the first cycle of a CHECK state, holds a stable
    // address until rd_valid is sampled high, then drops on that same edge.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tick_cnt    <= '0;
            heading1    <= 2'b01;
            heading2    <= 2'b11;
            x1          <= 8'(P1_X0);
            y1          <= 7'(P1_Y0);
            x2          <= 8'(P2_X0);
            y2          <= 7'(P2_Y0);
            cx1_q       <= '0;
            cy1_q       <= '0;
            cx2_q       <= '0;
            cy2_q       <= '0;
            crash       <= 2'b00;
            rd_req      <= 1'b0;
            rd_x        <= '0;
            rd_y        <= '0;
            plot        <= 1'b0;
            plot_x      <= '0;
            plot_y      <= '0;
            plot_colour <= '0;
            game_over   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            tick_cnt <= (state == WAIT_TICK && tick_cnt != TICK_LAST) ? tick_cnt + 1'b1 : '0;
            case (state)
                STEP: begin
                    heading1 <= new_h1;
                    heading2 <= new_h2;
                    cx1_q    <= cx1;
                    cy1_q    <= cy1;
                    cx2_q    <= cx2;
                    cy2_q    <= cy2;
                    crash    <= {wall2 | same, wall1 | same};
                end
                CHECK1: if (!crash[0]) begin
                    if (!rd_req) begin
                        rd_req <= 1'b1;
                        rd_x   <= cx1_q[7:0];
                        rd_y   <= cy1_q[6:0];
                    end else if (rd_valid) begin
                        rd_req   <= 1'b0;
                        crash[0] <= rd_data;
                    end
                end
                CHECK2: if (!crash[1]) begin
                    if (!rd_req) begin
                        rd_req <= 1'b1;
                        rd_x   <= cx2_q[7:0];
                        rd_y   <= cy2_q[6:0];
                    end else if (rd_valid) begin
                        rd_req   <= 1'b0;
                        crash[1] <= rd_data;
                    end
                end
                RESOLVE: if (crash == 2'b00) begin
                    x1 <= cx1_q[7:0];
                    y1 <= cy1_q[6:0];
                    x2 <= cx2_q[7:0];
                    y2 <= cy2_q[6:0];
                end
                default: ;
            endcase

            plot <= 1'b0;
            case (state_next)
                INIT1: begin
                    plot <= 1'b1; plot_x <= 8'(P1_X0); plot_y <= 7'(P1_Y0); plot_colour <= 3'b100;
                end
                INIT2: begin
                    plot <= 1'b1; plot_x <= 8'(P2_X0); plot_y <= 7'(P2_Y0); plot_colour <= 3'b001;
                end
                PLOT1: begin
                    plot <= 1'b1; plot_x <= cx1_q[7:0]; plot_y <= cy1_q[6:0]; plot_colour <= 3'b100;
                end
                PLOT2: begin
                    plot <= 1'b1; plot_x <= cx2_q[7:0]; plot_y <= cy2_q[6:0]; plot_colour <= 3'b001;
                end
                default: ;
            endcase
            game_over <= (state_next == OVER);
            busy      <= !(state_next == IDLE || state_next == WAIT_TICK || state_next == OVER);
        end
    end

    assign fsm_state = state;
endmodule
